// File: rtl/fc_rx_frame_checker_pkg.sv
// Shared FC RX definitions: delimiter words, error/state enums, and the CRC-32 word step.
package fc_rx_frame_checker_pkg;

  localparam logic [31:0] SOFI3  = 32'hBCB5_5656;
  localparam logic [31:0] SOFN3  = 32'hBCB5_3636;
  localparam logic [31:0] SOFI2  = 32'hBCB5_5555;
  localparam logic [31:0] SOFN2  = 32'hBCB5_3535;
  localparam logic [31:0] SOFF   = 32'hBCB5_5858;
  localparam logic [31:0] EOFT_N = 32'hBC95_7575;
  localparam logic [31:0] EOFT_P = 32'hBCB5_7575;
  localparam logic [31:0] EOFN_N = 32'hBC95_D5D5;
  localparam logic [31:0] EOFN_P = 32'hBCB5_D5D5;
  localparam logic [31:0] R_RDY  = 32'hBC95_4A4A;
  localparam logic [31:0] IDLE_P = 32'hBC95_B5B5;

  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

  typedef enum logic [2:0] {
    ERR_NONE, ERR_BAD_SOF, ERR_ORPHAN_EOP, ERR_NESTED_SOF,
    ERR_TOO_LONG, ERR_BAD_EOF, ERR_TOO_SHORT, ERR_CRC
  } rx_err_t;

  typedef enum logic [1:0] {ST_IDLE, ST_IN_FRAME, ST_DISCARD} rx_state_t;

  function automatic logic is_sof(logic [31:0] w);
    return w inside {SOFI3, SOFN3, SOFI2, SOFN2, SOFF};
  endfunction

  function automatic logic is_eof(logic [31:0] w);
    return w inside {EOFT_N, EOFT_P, EOFN_N, EOFN_P};
  endfunction

  // Non-reflected CRC-32, word bit 31 (MSB of the first byte) shifted in first.
  function automatic logic [31:0] crc32_word(logic [31:0] crc, logic [31:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      c = (c[31] ^ data[i]) ? ({c[30:0], 1'b0} ^ CRC_POLY) : {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/fc_rx_frame_checker_if.sv
// Avalon-ST word stream from the framer RX path into the frame checker.
interface fc_rx_frame_checker_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_startofpacket;
  logic        in_endofpacket;
  logic        in_ready;

  modport master (output in_data, in_valid, in_startofpacket, in_endofpacket,
                  input  in_ready);
  modport slave  (input  in_data, in_valid, in_startofpacket, in_endofpacket,
                  output in_ready);
endinterface

// File: rtl/fc_rx_frame_checker_crc32.sv
// fc_crc32: running CRC-32 over one 32-bit word per cycle; init restarts at CRC_INIT.
module fc_crc32
  import fc_rx_frame_checker_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        init_i,
  input  logic        data_valid_i,
  input  logic [31:0] data_i,
  output logic [31:0] crc_o
);
  logic [31:0] crc_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || init_i) crc_q <= CRC_INIT;
    else if (data_valid_i) crc_q <= crc32_word(crc_q, data_i);
  end

  assign crc_o = crc_q;
endmodule

// File: rtl/fc_rx_frame_checker.sv
// FC RX frame checker: classifies words as primitives/frames, checks delimiters, length and
// optional CRC (macro FC_RX_CRC_CHECK_EN), and keeps saturating R_RDY/frame/error counters.
// state       | meaning
// ST_IDLE     | between frames, primitives counted, SOF opens a frame
// ST_IN_FRAME | collecting frame words, EOF runs the checks
// ST_DISCARD  | rejected frame, drop words until eop
module fc_rx_frame_checker
  import fc_rx_frame_checker_pkg::*;
#(
  parameter int MIN_WORDS = 9,
  parameter int MAX_WORDS = 537,
  parameter int CNT_W     = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  fc_rx_frame_checker_if.slave  st,
  input  logic                  clear_counters_i,
  output logic                  in_frame_o,
  output logic                  frame_ok_o,
  output logic                  frame_err_o,
  output logic [2:0]            err_code_o,
  output logic [CNT_W-1:0]      rrdy_count_o,
  output logic [CNT_W-1:0]      frame_count_o,
  output logic [CNT_W-1:0]      err_count_o
);
  localparam int                LEN_W   = $clog2(MAX_WORDS + 1);
  localparam logic [LEN_W-1:0]  MAX_L   = LEN_W'(MAX_WORDS);
  localparam logic [LEN_W-1:0]  MIN_L   = LEN_W'(MIN_WORDS);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  rx_state_t         state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, len_inc;
  rx_err_t           code_q, code_d;
  logic              ok_q, ok_d, err_q, err_d, rrdy_inc, ready_q;
  logic [CNT_W-1:0]  rrdy_q, frames_q, errs_q;
  logic              accept, sop, eop, crc_bad;
  logic [31:0]       data;

  assign accept  = st.in_valid & ready_q;
  assign sop     = st.in_startofpacket;
  assign eop     = st.in_endofpacket;
  assign data    = st.in_data;
  assign len_inc = len_q + LEN_W'(1);

`ifdef FC_RX_CRC_CHECK_EN
  logic        crc_init, crc_valid;
  logic [31:0] crc_val;

  // CRC covers only words strictly between SOF and EOF, CRC word included.
  assign crc_init  = accept & sop & ~eop & is_sof(data) & (state_q != ST_DISCARD);
  assign crc_valid = accept & ~eop & (state_q == ST_IN_FRAME) & ~(sop & is_sof(data));
  assign crc_bad   = (crc_val != CRC_RESIDUE);

  fc_crc32 u_crc (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .init_i       (crc_init),
    .data_valid_i (crc_valid),
    .data_i       (data),
    .crc_o        (crc_val)
  );
`else
  assign crc_bad = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    code_d   = code_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    rrdy_inc = 1'b0;
    if (accept) begin
      if (sop && eop) begin
        rrdy_inc = (data == R_RDY);
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (sop && is_sof(data)) begin
              state_d = ST_IN_FRAME;
              len_d   = LEN_W'(1);
            end else if (sop) begin
              err_d   = 1'b1;
              code_d  = ERR_BAD_SOF;
              state_d = ST_DISCARD;
            end else if (eop) begin
              err_d   = 1'b1;
              code_d  = ERR_ORPHAN_EOP;
            end
          end
          ST_IN_FRAME: begin
            if (sop && is_sof(data)) begin
              err_d  = 1'b1;
              code_d = ERR_NESTED_SOF;
              len_d  = LEN_W'(1);
            end else if (len_inc > MAX_L) begin
              // An oversize word that is itself the eop leaves nothing to discard.
              err_d   = 1'b1;
              code_d  = ERR_TOO_LONG;
              len_d   = '0;
              state_d = eop ? ST_IDLE : ST_DISCARD;
            end else if (eop) begin
              len_d   = '0;
              state_d = ST_IDLE;
              if (!is_eof(data)) begin
                err_d = 1'b1; code_d = ERR_BAD_EOF;
              end else if (len_inc < MIN_L) begin
                err_d = 1'b1; code_d = ERR_TOO_SHORT;
              end else if (crc_bad) begin
                err_d = 1'b1; code_d = ERR_CRC;
              end else begin
                ok_d  = 1'b1;
              end
            end else begin
              len_d = len_inc;
            end
          end
          ST_DISCARD: if (eop) state_d = ST_IDLE;
          default:    state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      code_q   <= ERR_NONE;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      rrdy_q   <= '0;
      frames_q <= '0;
      errs_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      code_q   <= code_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      ready_q  <= 1'b1;
      if (clear_counters_i) begin
        rrdy_q   <= '0;
        frames_q <= '0;
        errs_q   <= '0;
      end else begin
        if (rrdy_inc && rrdy_q != CNT_MAX)   rrdy_q   <= rrdy_q + CNT_W'(1);
        if (ok_d && frames_q != CNT_MAX)     frames_q <= frames_q + CNT_W'(1);
        if (err_d && errs_q != CNT_MAX)      errs_q   <= errs_q + CNT_W'(1);
      end
    end
  end

  assign st.in_ready     = ready_q;
  assign in_frame_o      = (state_q == ST_IN_FRAME);
  assign frame_ok_o      = ok_q;
  assign frame_err_o     = err_q;
  assign err_code_o      = code_q;
  assign rrdy_count_o    = rrdy_q;
  assign frame_count_o   = frames_q;
  assign err_count_o     = errs_q;
endmodule

// File: tb/tb_fc_rx_frame_checker.sv
// Directed + randomized bench for fc_rx_frame_checker against a packet-level reference model.
module tb_fc_rx_frame_checker;
  import fc_rx_frame_checker_pkg::*;

  localparam int MINW = 9;
  localparam int MAXW = 537;
  localparam int CW   = 4;
`ifdef FC_RX_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, clear_counters;
  logic in_frame, frame_ok, frame_err;
  logic [2:0] err_code;
  logic [CW-1:0] rrdy_count, frame_count, err_count;

  always #5 clk = ~clk;

  fc_rx_frame_checker_if st();

  fc_rx_frame_checker #(.MIN_WORDS(MINW), .MAX_WORDS(MAXW), .CNT_W(CW)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .st               (st),
    .clear_counters_i (clear_counters),
    .in_frame_o       (in_frame),
    .frame_ok_o       (frame_ok),
    .frame_err_o      (frame_err),
    .err_code_o       (err_code),
    .rrdy_count_o     (rrdy_count),
    .frame_count_o    (frame_count),
    .err_count_o      (err_count)
  );

  int n_tests = 0, n_fail = 0;
  int exp_rrdy = 0, exp_frames = 0, exp_errs = 0;
  int got_ok, got_err, err_at, ok_at;
  logic [2:0] got_code;
  logic [31:0] pw[$];
  bit ps[$], pe[$];
  logic [31:0] sofs[5] = '{SOFI3, SOFN3, SOFI2, SOFN2, SOFF};
  logic [31:0] eofs[4] = '{EOFT_N, EOFT_P, EOFN_N, EOFN_P};

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(int x);
    return (x > (1 << CW) - 1) ? (1 << CW) - 1 : x;
  endfunction

  // Byte-serial CRC-32, MSB byte of each word first, init all-ones, no final inversion.
  function automatic logic [31:0] ref_crc(logic [31:0] w[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (w[i]) begin
      for (int k = 3; k >= 0; k--) begin
        c = c ^ {w[i][8*k +: 8], 24'h0};
        for (int b = 0; b < 8; b++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
      end
    end
    return c;
  endfunction

  task automatic add(logic [31:0] w, bit s, bit e);
    pw.push_back(w); ps.push_back(s); pe.push_back(e);
  endtask

  task automatic push_frame(logic [31:0] sofw, logic [31:0] body[$], logic [31:0] eofw, bit prim_in);
    add(sofw, 1, 0);
    if (prim_in) add(R_RDY, 1, 1);
    foreach (body[i]) add(body[i], 0, 0);
    add(eofw, 0, 1);
  endtask

  // n counts frame words SOF..EOF; with CRC enabled the last body word carries the CRC.
  task automatic add_frame(int n, logic [31:0] sofw, logic [31:0] eofw, bit corrupt, bit prim_in);
    logic [31:0] body[$];
    logic [31:0] pre[$];
    for (int i = 0; i < n - 2; i++) body.push_back($urandom);
    if (CRC_ON && n >= 3) begin
      for (int i = 0; i < n - 3; i++) pre.push_back(body[i]);
      body[n-3] = ~ref_crc(pre) ^ (corrupt ? 32'h0000_0100 : 32'h0);
    end
    push_frame(sofw, body, eofw, prim_in);
  endtask

  task automatic run_pkt(bit clr_last);
    got_ok = 0; got_err = 0; err_at = 0; ok_at = 0; got_code = '0;
    for (int i = 0; i < pw.size(); i++) begin
      @(negedge clk);
      st.in_valid = 1'b1; st.in_data = pw[i];
      st.in_startofpacket = ps[i]; st.in_endofpacket = pe[i];
      clear_counters = clr_last && (i == pw.size() - 1);
      @(posedge clk); #1;
      if (frame_ok) begin got_ok++; ok_at = i + 1; end
      if (frame_err) begin got_err++; got_code = err_code; if (err_at == 0) err_at = i + 1; end
    end
    @(negedge clk);
    st.in_valid = 1'b0; st.in_startofpacket = 1'b0; st.in_endofpacket = 1'b0;
    clear_counters = 1'b0;
    pw.delete(); ps.delete(); pe.delete();
  endtask

  task automatic check_counters(string tag);
    check({tag, "/rrdy_count"},  32'(rrdy_count),  sat(exp_rrdy));
    check({tag, "/frame_count"}, 32'(frame_count), sat(exp_frames));
    check({tag, "/err_count"},   32'(err_count),   sat(exp_errs));
    check({tag, "/in_frame"},    32'(in_frame),    0);
  endtask

  task automatic expect_frame(string tag, int n, bit eof_good, bit corrupt, bit prim_in);
    rx_err_t code;
    int at;
    if (n > MAXW)                code = ERR_TOO_LONG;
    else if (!eof_good)          code = ERR_BAD_EOF;
    else if (n < MINW)           code = ERR_TOO_SHORT;
    else if (CRC_ON && corrupt)  code = ERR_CRC;
    else                         code = ERR_NONE;
    at = (n > MAXW ? MAXW + 1 : n) + int'(prim_in);
    exp_rrdy += int'(prim_in);
    if (code == ERR_NONE) begin
      check({tag, "/ok"}, got_ok, 1);
      check({tag, "/ok_at"}, ok_at, at);
      check({tag, "/err"}, got_err, 0);
      exp_frames++;
    end else begin
      check({tag, "/err"}, got_err, 1);
      check({tag, "/code"}, 32'(got_code), 32'(code));
      check({tag, "/err_at"}, err_at, at);
      check({tag, "/ok"}, got_ok, 0);
      exp_errs++;
    end
    check_counters(tag);
  endtask

  task automatic expect_err(string tag, rx_err_t code, int at, int oks);
    check({tag, "/err"}, got_err, 1);
    check({tag, "/code"}, 32'(got_code), 32'(code));
    check({tag, "/err_at"}, err_at, at);
    check({tag, "/ok"}, got_ok, oks);
    exp_errs++;
    exp_frames += oks;
    check_counters(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] body[$];
    int n, k, kind;

    reset = 1'b1; clear_counters = 1'b0;
    st.in_valid = 1'b0; st.in_data = '0;
    st.in_startofpacket = 1'b0; st.in_endofpacket = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/in_ready", 32'(st.in_ready), 0);
    check("reset/frame_ok", 32'(frame_ok), 0);
    check("reset/frame_err", 32'(frame_err), 0);
    check("reset/err_code", 32'(err_code), 0);
    check_counters("reset");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset/in_ready", 32'(st.in_ready), 1);

    // Directed good frame with fixed payload words.
    for (int i = 1; i <= 9; i++) body.push_back(32'hF00F_0000 + 32'(i));
    if (CRC_ON) begin
      body.pop_back();
      body.push_back(~ref_crc(body));
    end
    push_frame(SOFI3, body, EOFT_N, 0);
    run_pkt(0);
    expect_frame("good11", 11, 1, 0, 0);

    // R_RDY primitives counted, other primitives ignored.
    add(R_RDY, 1, 1); add(IDLE_P, 1, 1); add(R_RDY, 1, 1); add(R_RDY, 1, 1);
    run_pkt(0);
    exp_rrdy += 3;
    check("rrdy/err", got_err, 0);
    check_counters("rrdy");

    add_frame(6, SOFI3, EOFT_N, 0, 0);  run_pkt(0); expect_frame("short6", 6, 1, 0, 0);
    add_frame(8, SOFN3, EOFN_P, 0, 0);  run_pkt(0); expect_frame("short8", 8, 1, 0, 0);
    add_frame(9, SOFF,  EOFT_P, 0, 0);  run_pkt(0); expect_frame("min9", 9, 1, 0, 0);
    add_frame(9, SOFI3, EOFT_N, 0, 1);  run_pkt(0); expect_frame("min9_prim", 9, 1, 0, 1);
    add_frame(8, SOFI3, EOFT_N, 0, 1);  run_pkt(0); expect_frame("short8_prim", 8, 1, 0, 1);
    add_frame(12, SOFI2, 32'h0012_3456, 0, 0); run_pkt(0); expect_frame("bad_eof", 12, 0, 0, 0);
    add_frame(5, SOFI3, 32'h0000_0001, 0, 0);  run_pkt(0); expect_frame("bad_eof_short", 5, 0, 0, 0);
    add_frame(MAXW, SOFI3, EOFT_N, 0, 0);      run_pkt(0); expect_frame("max537", MAXW, 1, 0, 0);
    add_frame(MAXW + 1, SOFI3, EOFT_N, 0, 0);  run_pkt(0); expect_frame("len538", MAXW + 1, 1, 0, 0);
    add_frame(602, SOFI3, EOFT_N, 0, 0);       run_pkt(0); expect_frame("long602", 602, 1, 0, 0);
    add_frame(10, SOFN2, EOFN_N, 0, 0);        run_pkt(0); expect_frame("after_long", 10, 1, 0, 0);

    // Bad SOF, then the rest of that packet is discarded silently.
    add(32'h1234_0000 | 32'($urandom_range(0, 65535)), 1, 0);
    for (int i = 0; i < 3; i++) add($urandom, 0, 0);
    add(EOFT_N, 0, 1);
    run_pkt(0);
    expect_err("bad_sof", ERR_BAD_SOF, 1, 0);

    add($urandom, 0, 1); run_pkt(0);
    expect_err("orphan_eop", ERR_ORPHAN_EOP, 1, 0);

    // Nested SOF restarts the frame; the new frame completes normally.
    add(SOFI3, 1, 0);
    for (int i = 0; i < 3; i++) add($urandom, 0, 0);
    add_frame(12, SOFN3, EOFT_N, 0, 0);
    run_pkt(0);
    expect_err("nested", ERR_NESTED_SOF, 5, 1);
    check("nested/held_code", 32'(err_code), 32'(ERR_NESTED_SOF));

`ifdef FC_RX_CRC_CHECK_EN
    add_frame(14, SOFI3, EOFT_N, 1, 0); run_pkt(0); expect_frame("crc_bad", 14, 1, 1, 0);
    add_frame(14, SOFI3, EOFT_N, 1, 0); run_pkt(1);
    check("crc_clr/err", got_err, 1);
    check("crc_clr/code", 32'(got_code), 32'(ERR_CRC));
    exp_rrdy = 0; exp_frames = 0; exp_errs = 0;
    check_counters("crc_clr");
`endif

    // Clear on the same cycle as a good EOF wins over the increment.
    add_frame(10, SOFI3, EOFT_N, 0, 0); run_pkt(1);
    check("clr/ok", got_ok, 1);
    exp_rrdy = 0; exp_frames = 0; exp_errs = 0;
    check_counters("clr");

    for (int i = 0; i < 20; i++) add(R_RDY, 1, 1);
    run_pkt(0);
    exp_rrdy += 20;
    check_counters("rrdy_sat");
    add(R_RDY, 1, 1); add(R_RDY, 1, 1); add_frame(2, SOFI3, EOFT_N, 0, 0); run_pkt(1);
    exp_rrdy = 0; exp_frames = 0; exp_errs = 0;
    check_counters("clr2");

    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin
          n = $urandom_range(MINW, 40);
          add_frame(n, sofs[$urandom_range(0, 4)], eofs[$urandom_range(0, 3)], 0, 0);
          run_pkt(0); expect_frame("rnd_good", n, 1, 0, 0);
        end
        1: begin
          n = $urandom_range(2, MINW - 1);
          add_frame(n, sofs[$urandom_range(0, 4)], eofs[$urandom_range(0, 3)], 0, 0);
          run_pkt(0); expect_frame("rnd_short", n, 1, 0, 0);
        end
        2: begin
          n = $urandom_range(2, 30);
          add_frame(n, SOFI3, 32'h00AB_0000 | 32'($urandom_range(0, 65535)), 0, 0);
          run_pkt(0); expect_frame("rnd_bad_eof", n, 0, 0, 0);
        end
        3: begin
          k = $urandom_range(1, 4);
          for (int i = 0; i < k; i++) add(R_RDY, 1, 1);
          run_pkt(0);
          exp_rrdy += k;
          check("rnd_rrdy/err", got_err, 0);
          check_counters("rnd_rrdy");
        end
        4: begin
          add(32'h0000_FFFF & $urandom, 0, 1); run_pkt(0);
          expect_err("rnd_orphan", ERR_ORPHAN_EOP, 1, 0);
        end
        default: begin
          add(32'h5500_0000 | 32'($urandom_range(0, 65535)), 1, 0);
          k = $urandom_range(0, 5);
          for (int i = 0; i < k; i++) add($urandom, 0, 0);
          add(EOFN_N, 0, 1);
          run_pkt(0);
          expect_err("rnd_bad_sof", ERR_BAD_SOF, 1, 0);
        end
      endcase
    end

    // Reset in the middle of a frame drops it without an error.
    add(SOFI3, 1, 0);
    for (int i = 0; i < 5; i++) add($urandom, 0, 0);
    for (int i = 0; i < pw.size(); i++) begin
      @(negedge clk);
      st.in_valid = 1'b1; st.in_data = pw[i];
      st.in_startofpacket = ps[i]; st.in_endofpacket = pe[i];
    end
    @(posedge clk); #1;
    check("midreset/in_frame_before", 32'(in_frame), 1);
    @(negedge clk);
    st.in_valid = 1'b0; st.in_startofpacket = 1'b0;
    pw.delete(); ps.delete(); pe.delete();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midreset/in_ready", 32'(st.in_ready), 0);
    exp_rrdy = 0; exp_frames = 0; exp_errs = 0;
    check_counters("midreset");
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);
    add_frame(11, SOFI3, EOFT_N, 0, 0); run_pkt(0);
    expect_frame("after_reset", 11, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
